uart_transmitter: RTL and testbench
===================================

# uart_transmitter

Serial UART transmitter that serializes a parallel byte onto `tx_out` as start bit, LSB-first data, optional parity and stop bit(s). It is paced by the same oversampling `tick` enable used by the UART receiver, so both ends of a link share one baud generator. It sits between the host-side byte source and the TX pin, and accepts one frame at a time through a start/busy/done handshake.

## Interface
- `DATA_WIDTH`, 8: data bits per frame.
- `OVERSAMPLE_RATE`, 16: `tick` pulses per bit period. Must be ≥ 2.
- `PARITY_EN`, 0: 1 inserts a parity bit after the data bits.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd parity. Ignored when `PARITY_EN`=0.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.

- `clk` in 1: single clock. All state is updated on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `tick` in 1: baud-oversample enable, one `clk` wide.
- `tx_start` in 1: request to send `tx_in`. Sampled only in IDLE.
- `tx_in` in DATA_WIDTH: byte to send. Captured on the accept edge.
- `tx_out` out 1: serial line, idle high.
- `tx_busy` out 1: high whenever state ≠ IDLE. Decoded combinationally from the state register.
- `tx_done` out 1: registered pulse, one `clk` wide, marks the end of a frame.

## Operation
- States are IDLE, START, DATA, PARITY, STOP.
- **Reset** (`rst_n`=0 at a rising edge):
  - state = IDLE, `tx_out` = 1, `tx_done` = 0, `tx_busy` = 0.
  - tick counter, bit counter and shift register are cleared.
  - Reset mid-frame aborts the frame. The line is high from the next cycle and no `tx_done` is issued.
- **IDLE**:
  - `tx_out` = 1.
  - If `tx_start` = 1: capture `tx_in` into the shift register, compute the parity bit, clear the tick counter, go to START.
  - `tx_start` and `tx_in` are ignored in every other state.
- **Bit timing rule** (START, DATA, PARITY, STOP):
  - On each `tick`: if the tick counter = OVERSAMPLE_RATE-1, clear it and end the bit; otherwise increment it.
  - Cycles without `tick` hold all state.
- **START**: `tx_out` = 0. At bit end, clear the bit counter and go to DATA.
- **DATA**:
  - `tx_out` = shift register bit 0, so bits go out LSB first.
  - At bit end, shift right by one.
  - If the bit counter = DATA_WIDTH-1, go to PARITY (when `PARITY_EN`) or STOP. Otherwise increment the bit counter.
- **PARITY**:
  - `tx_out` = XOR of the captured data, inverted when `PARITY_ODD`=1.
  - At bit end, go to STOP.
- **STOP**:
  - `tx_out` = 1, held for STOP_BITS bit periods; the bit counter counts the stop bits.
  - At the end of the last stop bit, go to IDLE and set `tx_done` = 1 for one cycle.
- **Output register**:
  - `tx_out` is registered, with no glitches. Its value always reflects the current state.
- **Counter widths**:
  - Tick counter is clog2(OVERSAMPLE_RATE) bits.
  - Bit counter is clog2(DATA_WIDTH)+1 bits.
  - Neither counter can wrap inside a bit.

## Timing
- **Accept**: `tx_start`=1 in IDLE at edge N. After edge N, `tx_out`=0 and `tx_busy`=1.
- **Start bit length**: ends on the OVERSAMPLE_RATE-th `tick` strictly after edge N.
- **Other bits**: each lasts exactly OVERSAMPLE_RATE ticks.
- **Frame length** (ticks): (1 + DATA_WIDTH + PARITY_EN + STOP_BITS) × OVERSAMPLE_RATE.
- **End of frame**:
  - On the last stop tick edge E, the state returns to IDLE.
  - After E: `tx_busy`=0 and `tx_done`=1 in the same cycle.
  - `tx_done` returns to 0 after E+1.
- **Back-to-back**:
  - `tx_start`=1 in the cycle where `tx_done`=1 is accepted, because the state is IDLE.
  - The line stays high for exactly that one `clk` between frames.
- **Held start**: `tx_start` held high continuously sends the `tx_in` value present at each accept edge.
- **Latency**: `tick` does not have to be present at accept; latency from `tx_start` to the falling edge of `tx_out` is always 1 `clk`.

## Test plan
- **Reset**: hold `rst_n`=0 for 3 cycles with `tx_start`=1. Required: `tx_out`=1, `tx_busy`=0, `tx_done`=0 throughout, and no frame starts.
- **Basic frame**: defaults, `tick` every 4 `clk`, send 0xA5. Required:
  - Line samples at mid-bit read 0,1,0,1,0,0,1,0,1,1.
  - Frame is 160 ticks.
  - One `tx_done` pulse, coincident with `tx_busy` falling.
- **Even parity**: `PARITY_EN`=1, `PARITY_ODD`=0, send 0xA5. Required: parity bit 0 and frame 176 ticks. With `PARITY_ODD`=1, 0x01 gives parity bit 0 and 0x00 gives parity bit 1.
- **Two stop bits**: `STOP_BITS`=2, send 0xFF. Required: line high for 32 ticks after the last data bit before `tx_done`, and total frame 176 ticks.
- **Back-to-back**: assert `tx_start` in the `tx_done` cycle with 0x3C, after 0xC3. Required:
  - The second start bit begins on the next `clk`.
  - The first frame's data is not corrupted.
  - `tx_start` pulses during busy are ignored.
- **Reset mid-frame**: pulse `rst_n`=0 during data bit 3. Required: `tx_out`=1 on the next cycle, no `tx_done`, and a fresh 0x5A frame sends correctly afterwards.

Source files
------------

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// Bit periods are paced by the shared oversampling tick; tx_out is registered from the next state.
module uart_transmitter #(
  parameter int DATA_WIDTH      = 8,
  parameter int OVERSAMPLE_RATE = 16,
  parameter int PARITY_EN       = 0,
  parameter int PARITY_ODD      = 0,
  parameter int STOP_BITS       = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic                  tx_start,
  input  logic [DATA_WIDTH-1:0] tx_in,
  output logic                  tx_out,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int TICK_W = $clog2(OVERSAMPLE_RATE);
  localparam int BIT_W  = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                state_q, state_d;
  logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic                  tx_out_q, tx_out_d;
  logic                  tx_done_q, tx_done_d;
  logic                  bit_end;

  assign bit_end = tick && (tick_cnt_q == TICK_W'(OVERSAMPLE_RATE - 1));

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path infers a latch.
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    tx_done_d  = 1'b0;

    if (state_q != S_IDLE && tick) begin
      tick_cnt_d = bit_end ? '0 : tick_cnt_q + TICK_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          shift_d    = tx_in;
          parity_d   = (^tx_in) ^ (PARITY_ODD != 0);
          tick_cnt_d = '0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
            // Cleared here so STOP can reuse the counter for its stop bits.
            bit_cnt_d = '0;
            state_d   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_cnt_q == BIT_W'(STOP_BITS - 1)) begin
            state_d   = S_IDLE;
            tx_done_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level follows the state being entered, so the register tracks state with no lag.
    tx_out_d = 1'b1;
    case (state_d)
      S_START:  tx_out_d = 1'b0;
      S_DATA:   tx_out_d = shift_d[0];
      S_PARITY: tx_out_d = parity_d;
      default:  tx_out_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tx_out_q   <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_out_q   <= tx_out_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign tx_out  = tx_out_q;
  assign tx_busy = (state_q != S_IDLE);
  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: four parameterisations share clk, tick and reset;
// frames are sampled mid-bit and compared against hand-computed line patterns.
module tb_uart_transmitter;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic [7:0] tx_in;
  logic [3:0] start_v;
  logic [3:0] tx_out_v, tx_busy_v, tx_done_v;
  logic [1:0] sel;
  logic       tx_out_s, tx_busy_s, tx_done_s;

  int n_checks;
  int n_bad;

  // 0: defaults, 1: even parity, 2: odd parity, 3: two stop bits
  uart_transmitter u_def (
    .clk(clk), .rst_n(rst_n), .tick(tick), .tx_start(start_v[0]), .tx_in(tx_in),
    .tx_out(tx_out_v[0]), .tx_busy(tx_busy_v[0]), .tx_done(tx_done_v[0])
  );
  uart_transmitter #(.PARITY_EN(1), .PARITY_ODD(0)) u_even (
    .clk(clk), .rst_n(rst_n), .tick(tick), .tx_start(start_v[1]), .tx_in(tx_in),
    .tx_out(tx_out_v[1]), .tx_busy(tx_busy_v[1]), .tx_done(tx_done_v[1])
  );
  uart_transmitter #(.PARITY_EN(1), .PARITY_ODD(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .tick(tick), .tx_start(start_v[2]), .tx_in(tx_in),
    .tx_out(tx_out_v[2]), .tx_busy(tx_busy_v[2]), .tx_done(tx_done_v[2])
  );
  uart_transmitter #(.STOP_BITS(2)) u_stop2 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .tx_start(start_v[3]), .tx_in(tx_in),
    .tx_out(tx_out_v[3]), .tx_busy(tx_busy_v[3]), .tx_done(tx_done_v[3])
  );

  always_comb begin
    tx_out_s  = tx_out_v[sel];
    tx_busy_s = tx_busy_v[sel];
    tx_done_s = tx_done_v[sel];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One-clk tick every 4 clk, changed on the falling edge.
  initial begin
    tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic start_frame(input logic [1:0] s, input logic [7:0] d);
    @(negedge clk);
    sel        = s;
    tx_in      = d;
    start_v[s] = 1'b1;
    @(posedge clk);
    #1;
    check("accept_line", tx_out_s, 1'b0);
    check("accept_busy", tx_busy_s, 1'b1);
    start_v[s] = 1'b0;
    tx_in      = ~d;
  endtask

  // Counts ticks after accept, samples the line at tick 8 of each bit, and checks the done pulse.
  task automatic capture(input logic [1:0] s, input int data_end, input bit chain,
                         input logic [7:0] next_data, input bit poke,
                         output logic [11:0] bits, output int ticks, output bit stop_low);
    int nb;
    bit got;
    bit t;
    bit prev_busy;
    bits      = '0;
    ticks     = 0;
    nb        = 0;
    got       = 1'b0;
    stop_low  = 1'b0;
    prev_busy = 1'b1;
    for (int c = 0; c < 3000 && !got; c++) begin
      @(posedge clk);
      t = tick;
      #1;
      if (poke && c == 100) begin
        start_v[s] = 1'b1;
        tx_in      = 8'h00;
      end else if (poke && c == 101) begin
        start_v[s] = 1'b0;
      end
      if (t) begin
        ticks++;
        if (ticks % 16 == 8 && nb < 12) begin
          bits[nb] = tx_out_s;
          nb++;
        end
      end
      if (ticks >= data_end && !tx_out_s) stop_low = 1'b1;
      if (tx_done_s) begin
        got = 1'b1;
        check("busy_before_done", prev_busy, 1'b1);
        check("done_busy", tx_busy_s, 1'b0);
        check("done_line", tx_out_s, 1'b1);
        if (chain) begin
          tx_in      = next_data;
          start_v[s] = 1'b1;
        end
        @(posedge clk);
        #1;
        check("done_width", tx_done_s, 1'b0);
        if (chain) begin
          check("b2b_line", tx_out_s, 1'b0);
          check("b2b_busy", tx_busy_s, 1'b1);
          start_v[s] = 1'b0;
        end
      end
      prev_busy = tx_busy_s;
    end
    if (!got) check("frame_timeout", 32'd0, 32'd1);
  endtask

  logic [11:0] bits;
  int          ticks;
  bit          stop_low;
  int          dones;

  initial begin
    n_checks = 0;
    n_bad    = 0;
    sel      = 2'd0;
    tx_in    = 8'h00;
    start_v  = 4'hF;
    rst_n    = 1'b0;

    // Reset held 3 cycles with tx_start asserted
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_line", tx_out_s, 1'b1);
      check("rst_busy", tx_busy_s, 1'b0);
      check("rst_done", tx_done_s, 1'b0);
    end
    @(negedge clk);
    start_v = 4'h0;
    rst_n   = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_busy", {28'd0, tx_busy_v}, 32'd0);

    // Basic frame 0xA5
    start_frame(2'd0, 8'hA5);
    capture(2'd0, 144, 1'b0, 8'h00, 1'b0, bits, ticks, stop_low);
    check("a5_bits", bits, 12'h34A);
    check("a5_ticks", ticks, 160);
    check("a5_stop", stop_low, 1'b0);

    // Even parity 0xA5
    start_frame(2'd1, 8'hA5);
    capture(2'd1, 160, 1'b0, 8'h00, 1'b0, bits, ticks, stop_low);
    check("even_a5_bits", bits, 12'h54A);
    check("even_a5_ticks", ticks, 176);

    // Odd parity 0x01 and 0x00
    start_frame(2'd2, 8'h01);
    capture(2'd2, 160, 1'b0, 8'h00, 1'b0, bits, ticks, stop_low);
    check("odd_01_bits", bits, 12'h402);
    check("odd_01_ticks", ticks, 176);
    start_frame(2'd2, 8'h00);
    capture(2'd2, 160, 1'b0, 8'h00, 1'b0, bits, ticks, stop_low);
    check("odd_00_bits", bits, 12'h600);

    // Two stop bits 0xFF
    start_frame(2'd3, 8'hFF);
    capture(2'd3, 144, 1'b0, 8'h00, 1'b0, bits, ticks, stop_low);
    check("stop2_bits", bits, 12'h7FE);
    check("stop2_ticks", ticks, 176);
    check("stop2_high", stop_low, 1'b0);

    // Back-to-back 0xC3 then 0x3C, with a start pulse mid-frame
    start_frame(2'd0, 8'hC3);
    capture(2'd0, 144, 1'b1, 8'h3C, 1'b1, bits, ticks, stop_low);
    check("c3_bits", bits, 12'h386);
    check("c3_ticks", ticks, 160);
    tx_in = 8'h00;
    capture(2'd0, 144, 1'b0, 8'h00, 1'b0, bits, ticks, stop_low);
    check("3c_bits", bits, 12'h278);
    check("3c_ticks", ticks, 160);

    // Reset during data bit 3
    start_frame(2'd0, 8'h00);
    ticks = 0;
    for (int c = 0; c < 1000 && ticks < 72; c++) begin
      @(posedge clk);
      if (tick) ticks++;
    end
    #1;
    check("pre_rst_line", tx_out_s, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_line", tx_out_s, 1'b1);
    check("mid_rst_busy", tx_busy_s, 1'b0);
    check("mid_rst_done", tx_done_s, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 700; c++) begin
      @(posedge clk);
      #1;
      if (tx_done_s) dones++;
      if (!tx_out_s) dones += 100;
    end
    check("mid_rst_quiet", dones, 0);
    start_frame(2'd0, 8'h5A);
    capture(2'd0, 144, 1'b0, 8'h00, 1'b0, bits, ticks, stop_low);
    check("5a_bits", bits, 12'h2B4);
    check("5a_ticks", ticks, 160);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
